// File: rtl/bp_fe_queue_roll_if.sv
// FE->BE fetch-queue bundle; signal suffixes are from the queue's point of view.
// slave = the queue itself, master = the FE/BE pair driving it.
interface bp_fe_queue_roll_if #(
    parameter int width_p = 32
);
    logic [width_p-1:0] fe_queue_i;
    logic               fe_queue_v_i;
    logic               fe_queue_ready_o;
    logic [width_p-1:0] fe_queue_o;
    logic               fe_queue_v_o;
    logic               fe_queue_yumi_i;
    logic               fe_queue_deq_i;
    logic               fe_queue_roll_i;
    logic               fe_queue_clr_i;

    modport slave (
        input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i,
               fe_queue_deq_i, fe_queue_roll_i, fe_queue_clr_i,
        output fe_queue_ready_o, fe_queue_o, fe_queue_v_o
    );

    modport master (
        output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i,
               fe_queue_deq_i, fe_queue_roll_i, fe_queue_clr_i,
        input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o
    );
endinterface

// File: rtl/bp_fe_queue_roll.sv
// Rollback FIFO (write/speculative-read/commit pointers); enq->v_o and roll/clr->o in 1 cycle.
// Backpressure: ready drops when uncommitted entries fill the queue; no write-to-read bypass.
module bp_fe_queue_roll #(
    parameter int fe_queue_width_p = 32,
    parameter int els_p            = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    bp_fe_queue_roll_if.slave    q_if
);
    localparam int idx_w_lp     = $clog2(els_p);
    localparam int ptr_width_lp = idx_w_lp + 1;

    logic [ptr_width_lp-1:0]     wptr_q, wptr_d;
    logic [ptr_width_lp-1:0]     rptr_q, rptr_d;
    logic [ptr_width_lp-1:0]     cptr_q, cptr_d;
    logic [ptr_width_lp-1:0]     cptr_next;
    logic [fe_queue_width_p-1:0] mem_q [els_p];

    logic full, empty_rd, enq;

    // Occupancy is measured against the commit pointer so replayable entries stay protected.
    assign full     = (wptr_q[ptr_width_lp-1] != cptr_q[ptr_width_lp-1])
                    && (wptr_q[idx_w_lp-1:0] == cptr_q[idx_w_lp-1:0]);
    assign empty_rd = (rptr_q == wptr_q);

    assign q_if.fe_queue_ready_o = ~reset_i & ~full;
    assign q_if.fe_queue_v_o     = ~reset_i & ~empty_rd;
    assign q_if.fe_queue_o       = mem_q[rptr_q[idx_w_lp-1:0]];

    assign enq       = q_if.fe_queue_v_i & q_if.fe_queue_ready_o & ~q_if.fe_queue_clr_i;
    assign cptr_next = cptr_q + ptr_width_lp'(q_if.fe_queue_deq_i);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cptr_d = cptr_q;
        if (q_if.fe_queue_clr_i) begin
            rptr_d = wptr_q;
            cptr_d = wptr_q;
        end else if (q_if.fe_queue_roll_i) begin
            wptr_d = wptr_q + ptr_width_lp'(enq);
            rptr_d = cptr_next;
            cptr_d = cptr_next;
        end else begin
            wptr_d = wptr_q + ptr_width_lp'(enq);
            rptr_d = rptr_q + ptr_width_lp'(q_if.fe_queue_yumi_i);
            cptr_d = cptr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q[idx_w_lp-1:0]] <= q_if.fe_queue_i;
        end
    end

    // BE/FE protocol obligations; the queue itself does not guard against these.
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        q_if.fe_queue_yumi_i |-> q_if.fe_queue_v_o);
    a_deq_needs_read: assert property (@(posedge clk_i) disable iff (reset_i)
        q_if.fe_queue_deq_i |-> (cptr_q != rptr_q));
    a_fe_data_stable: assert property (@(posedge clk_i) disable iff (reset_i)
        (q_if.fe_queue_v_i & ~q_if.fe_queue_ready_o)
            |=> (~q_if.fe_queue_v_i | $stable(q_if.fe_queue_i)));
endmodule

// File: doc/bp_fe_queue_roll.md
Name: bp_fe_queue_roll

Overview:
- Rollback-capable FIFO between the front end's fetch output and the back end's checker.
- FE side:
  - Writes fetch packets with a valid/ready handshake.
  - Each accepted packet is one entry.
- BE side:
  - Speculatively reads entries using valid/yumi.
  - Commits read entries using deq.
  - Replays uncommitted entries using roll.
  - Flushes the queue using clr.
- Uses three pointers: write, speculative read, and committed. Entries stay resident until committed, so a BE flush can replay them without FE refetch.

Parameters:
- bp_params_p, e_bp_inv_cfg: processor config. Derives fe_queue_width_lp, the packet width `bp_fe_queue_width.
- els_p, 8: queue depth in entries. Must be a power of 2 and ≥2.
- ptr_width_lp, `BSG_SAFE_CLOG2(els_p)+1: pointer width; includes 1 wrap bit (localparam).

Ports:
- clk_i  in  1  clock. All state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- fe_queue_i  in  fe_queue_width_lp  packet from FE.
- fe_queue_v_i  in  1  FE packet valid.
- fe_queue_ready_o  out  1  queue can accept a packet this cycle.
- fe_queue_o  out  fe_queue_width_lp  entry at the read pointer.
- fe_queue_v_o  out  1  fe_queue_o holds an unread entry.
- fe_queue_yumi_i  in  1  BE consumes fe_queue_o. Advances the read pointer.
- fe_queue_deq_i  in  1  BE commits the oldest read-but-uncommitted entry.
- fe_queue_roll_i  in  1  read pointer returns to the committed pointer (replay).
- fe_queue_clr_i  in  1  discard all entries.

Behaviour:
- State:
  - Pointers wptr, rptr and cptr, each ptr_width_lp bits.
  - Storage: els_p x fe_queue_width_lp, 1 write port, 1 asynchronous read port.
  - The low log2(els_p) bits index storage. The MSB is the wrap bit.
- Reset: while reset_i=1, at each edge wptr=rptr=cptr=0. Outputs during reset and the first cycle after:
  - fe_queue_ready_o=0 during reset, 1 after.
  - fe_queue_v_o=0.
  - fe_queue_o is don't-care.
  - Storage is not cleared.
- Derived signals:
  - full = (wptr[msb]!=cptr[msb]) & (wptr[low]==cptr[low]). Occupancy is counted against cptr, so read-but-uncommitted entries still occupy space.
  - empty_rd = (rptr==wptr).
  - fe_queue_ready_o = ~reset_i & ~full.
  - fe_queue_v_o = ~reset_i & ~empty_rd.
  - fe_queue_o = mem[rptr[low]], combinational.
- Enqueue:
  - enq = fe_queue_v_i & fe_queue_ready_o & ~fe_queue_clr_i.
  - On enq, mem[wptr] is written and wptr++ (modulo 2^ptr_width_lp).
  - No write-to-read bypass: a written entry is first visible at fe_queue_v_o on the next cycle.
- Read: yumi with no roll and no clr → rptr++.
- Commit: deq with no clr → cptr++.
- Precedence per cycle, evaluated on pre-edge values:
  1. clr: rptr<=wptr and cptr<=wptr, using wptr before any enqueue. The same-cycle FE write is dropped (ready is effectively masked). yumi, deq and roll are ignored.
  2. roll (no clr): rptr<=cptr_next, where cptr_next = cptr+deq. yumi is ignored.
  3. Otherwise the independent updates enq, yumi and deq apply together.
- Simultaneous events:
  - enq+yumi on a 1-entry read window: rptr catches wptr_old. The new entry is visible next cycle.
  - Full, with deq and enq in the same cycle: enq is not accepted, because ready is computed pre-edge. Full clears next cycle.
- Legality (checked by simulation assertions, not handled in RTL):
  - yumi only when fe_queue_v_o=1.
  - deq only when cptr!=rptr.
  - fe_queue_i must be stable while fe_queue_v_i=1 & ~fe_queue_ready_o. This is an FE obligation; the queue samples only on enq.
- Wrap-around: pointers wrap naturally. The wrap bit distinguishes full from empty.
- Reset mid-operation: all pointers return to 0 at the next edge. Any in-flight handshake in that cycle is lost.
- Latency: enq→v_o is 1 cycle. roll/clr→new v_o/o is 1 cycle.

Test Plan:
- Reset, then enq A,B,C on consecutive cycles → v_o rises the cycle after A. Yumi each cycle returns A,B,C in order. v_o=0 after C. ready_o stays 1.
- els_p=8: enq 8 entries, yumi 8, no deq → ready_o=0, v_o=0. One deq → ready_o=1 next cycle. Enq I → accepted, wptr wraps to 9 (index 1).
- Enq A..D, yumi A,B,C, deq A, then roll → next cycle fe_queue_o=B, v_o=1. Subsequent yumis return B,C,D.
- Roll and deq in the same cycle with A,B read and uncommitted → cptr=1, rptr=1, fe_queue_o=B next cycle.
- Clr asserted together with fe_queue_v_i=1 (packet E) on 3 resident entries → next cycle v_o=0, ready_o=1. E not stored. rptr=cptr=wptr=3.
- Assert reset_i for 1 cycle while the queue holds 5 entries → all pointers 0, v_o=0. ready_o=0 during reset, 1 the cycle after.
